// File: rtl/carry_select_subtractor.sv
// Carry-select subtractor: registers {c_out, sum} = a + ~b + c_in.
// The lowest block ripples from c_in; each higher block precomputes both
// carry-in cases and picks one with the carry from the block below.
module carry_select_subtractor #(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
);

  // WIDTH must be a multiple of BLOCK; any remainder bits would be left undriven.
  localparam int NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] b_inv;
  logic [NBLK:0]    blk_carry;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_reg;
  logic             c_out_reg;
  logic             out_valid_reg;

  // The subtrahend is inverted bitwise before it reaches any adder.
  assign b_inv        = ~b;
  assign blk_carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
      if (gi == 0) begin : g_first
        // The lowest block is a single ripple chain fed by c_in.
        logic [BLOCK:0]   rc;
        logic [BLOCK-1:0] rs;
        assign rc[0] = blk_carry[0];
        for (genvar gj = 0; gj < BLOCK; gj++) begin : g_fa
          assign rs[gj]   = a[gi*BLOCK+gj] ^ b_inv[gi*BLOCK+gj] ^ rc[gj];
          assign rc[gj+1] = (a[gi*BLOCK+gj] & b_inv[gi*BLOCK+gj]) |
                            (rc[gj] & (a[gi*BLOCK+gj] ^ b_inv[gi*BLOCK+gj]));
        end
        assign sum_next[gi*BLOCK +: BLOCK] = rs;
        assign blk_carry[gi+1]             = rc[BLOCK];
      end else begin : g_sel
        // Two speculative ripple chains, carry-in 0 and carry-in 1.
        logic [BLOCK:0]   c0;
        logic [BLOCK:0]   c1;
        logic [BLOCK-1:0] s0;
        logic [BLOCK-1:0] s1;
        assign c0[0] = 1'b0;
        assign c1[0] = 1'b1;
        for (genvar gj = 0; gj < BLOCK; gj++) begin : g_fa
          assign s0[gj]   = a[gi*BLOCK+gj] ^ b_inv[gi*BLOCK+gj] ^ c0[gj];
          assign c0[gj+1] = (a[gi*BLOCK+gj] & b_inv[gi*BLOCK+gj]) |
                            (c0[gj] & (a[gi*BLOCK+gj] ^ b_inv[gi*BLOCK+gj]));
          assign s1[gj]   = a[gi*BLOCK+gj] ^ b_inv[gi*BLOCK+gj] ^ c1[gj];
          assign c1[gj+1] = (a[gi*BLOCK+gj] & b_inv[gi*BLOCK+gj]) |
                            (c1[gj] & (a[gi*BLOCK+gj] ^ b_inv[gi*BLOCK+gj]));
        end
        // The carry from the block below picks the real result.
        assign sum_next[gi*BLOCK +: BLOCK] = blk_carry[gi] ? s1 : s0;
        assign blk_carry[gi+1]             = blk_carry[gi] ? c1[BLOCK] : c0[BLOCK];
      end
    end
  endgenerate

  // Capture the result on valid input; hold it otherwise, valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      c_out_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg   <= sum_next;
        c_out_reg <= blk_carry[NBLK];
      end
    end
  end

  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_carry_select_subtractor.sv
// Bench for carry_select_subtractor (WIDTH=4, BLOCK=2): directed table,
// hold/reset sequences, exhaustive sweep and random stimulus.
module tb_carry_select_subtractor;

  localparam int WIDTH = 4;
  localparam int BLOCK = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  carry_select_subtractor #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .sum       (sum),
    .c_out     (c_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] exp_sum;
    logic       exp_c_out;
  } vec_t;

  vec_t vecs[5];

  // Reference: signed difference a - b - borrow_in; no borrow means diff >= 0.
  function automatic void model(input int av, input int bv, input int cv,
                                output logic [3:0] s, output logic co);
    int diff;
    diff = av - bv - (1 - cv);
    co   = (diff >= 0);
    s    = 4'((diff + 16) % 16);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive one captured input, then sample 1 time unit after the edge.
  task automatic apply(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    a = av; b = bv; c_in = cv; in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] es;
  logic       ec;
  logic [3:0] held_sum;
  logic       held_c;

  initial begin
    vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd15, 1'b0};
    vecs[1] = '{4'd3,  4'd0,  1'b0, 4'd2,  1'b1};
    vecs[2] = '{4'd7,  4'd3,  1'b1, 4'd4,  1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b1, 4'd0,  1'b1};
    vecs[4] = '{4'd0,  4'd1,  1'b1, 4'd15, 1'b0};

    rst_n = 1'b0; a = '0; b = '0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("reset_sum", int'(sum), 0);
    check("reset_c_out", int'(c_out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    // Directed table, applied back-to-back
    for (int i = 0; i < 5; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c_in);
      check($sformatf("dir%0d_sum", i), int'(sum), int'(vecs[i].exp_sum));
      check($sformatf("dir%0d_c_out", i), int'(c_out), int'(vecs[i].exp_c_out));
      check($sformatf("dir%0d_valid", i), int'(out_valid), 1);
      $display("[TB] dir a=%0d b=%0d c_in=%0d -> sum=%0d c_out=%0d", vecs[i].a, vecs[i].b, vecs[i].c_in, sum, c_out);
    end

    // Hold: in_valid=0 keeps the last result, out_valid drops
    a = 4'd9; b = 4'd2; c_in = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_sum", int'(sum), 15);
    check("hold_c_out", int'(c_out), 0);
    check("hold_valid", int'(out_valid), 0);
    $display("[TB] hold sum=%0d c_out=%0d valid=%0d", sum, c_out, out_valid);

    // Reset asserted between edges while a result is valid
    apply(4'd7, 4'd3, 1'b1);
    check("pre_rst_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sum", int'(sum), 0);
    check("midrst_c_out", int'(c_out), 0);
    check("midrst_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    check("inrst_valid", int'(out_valid), 0);
    check("inrst_sum", int'(sum), 0);
    #2 rst_n = 1'b1;
    apply(4'd12, 4'd5, 1'b0);
    check("postrst_sum", int'(sum), 6);
    check("postrst_c_out", int'(c_out), 1);
    check("postrst_valid", int'(out_valid), 1);
    $display("[TB] post-reset sum=%0d c_out=%0d valid=%0d", sum, c_out, out_valid);

    // Exhaustive sweep, one capture per cycle
    for (int i = 0; i < 512; i++) begin
      model(i[8:5], i[4:1], int'(i[0]), es, ec);
      apply(4'(i[8:5]), 4'(i[4:1]), i[0]);
      check($sformatf("sweep_a%0d_b%0d_c%0d_sum", i[8:5], i[4:1], i[0]), int'(sum), int'(es));
      check($sformatf("sweep_a%0d_b%0d_c%0d_c_out", i[8:5], i[4:1], i[0]), int'(c_out), int'(ec));
      check("sweep_valid", int'(out_valid), 1);
    end
    $display("[TB] sweep of 512 combinations done");

    // Random stimulus with random in_valid gaps
    held_sum = sum; held_c = c_out;
    for (int i = 0; i < 300; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      c_in = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 3) != 0);
      if (in_valid) begin
        model(int'(a), int'(b), int'(c_in), held_sum, held_c);
      end
      @(posedge clk); #1;
      check("rand_sum", int'(sum), int'(held_sum));
      check("rand_c_out", int'(c_out), int'(held_c));
      check("rand_valid", int'(out_valid), int'(in_valid));
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
